mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified instruction/data memory between the fetch path (IF) and the load/store path (DM).

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/arb_wait_counter.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM state codes and
// owner encoding used by mem_port_arbiter and its wait counter.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_RESP  = 2'd3
   } arb_state_e;

   localparam logic OWNER_IF = 1'b0;
   localparam logic OWNER_DM = 1'b1;

endpackage

// File: rtl/arb_wait_counter.sv
// Memory latency counter for mem_port_arbiter: loaded with MEM_LATENCY-1 when
// an access is issued, counts down while waiting, flags zero when the read
// data from the memory macro is valid. Saturates at zero, never wraps.
module arb_wait_counter #(
   parameter int MEM_LATENCY = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic dec_i,
   output logic zero_o
);

   localparam int CW = $clog2(MEM_LATENCY) + 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: load has priority, decrement stops at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CW'(MEM_LATENCY - 1);
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified instruction/data memory between
// the fetch path (IF) and the load/store path (DM). One transaction at a time
// through IDLE -> ISSUE -> WAIT -> RESP.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate grants on
// contention; otherwise DM has fixed priority over IF.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MEM_ADDR_W  = 10,
   parameter int MEM_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req_i,
   input  logic [31:0]           if_addr_i,
   input  logic                  if_flush_i,
   input  logic                  halt_i,
   output logic                  if_ack_o,
   output logic [31:0]           if_rdata_o,
   input  logic                  dm_req_i,
   input  logic                  dm_we_i,
   input  logic [3:0]            dm_be_i,
   input  logic [31:0]           dm_addr_i,
   input  logic [31:0]           dm_wdata_i,
   output logic                  dm_ack_o,
   output logic [31:0]           dm_rdata_o,
   output logic                  mem_en_o,
   output logic                  mem_we_o,
   output logic [3:0]            mem_be_o,
   output logic [MEM_ADDR_W-1:0] mem_addr_o,
   output logic [31:0]           mem_wdata_o,
   input  logic [31:0]           mem_rdata_i,
   output logic                  busy_o,
   output logic                  owner_o
);

   arb_state_e            state_q;
   logic                  owner_q;
   logic                  store_q;
   logic                  flush_q;
   logic                  mem_en_q;
   logic                  mem_we_q;
   logic [3:0]            mem_be_q;
   logic [MEM_ADDR_W-1:0] mem_addr_q;
   logic [31:0]           mem_wdata_q;
   logic                  if_ack_q;
   logic                  dm_ack_q;
   logic [31:0]           if_rdata_q;
   logic [31:0]           dm_rdata_q;
   logic                  busy_q;
`ifdef ARB_ROUND_ROBIN_EN
   logic                  last_owner_q;
`endif

   logic if_elig;
   logic any_req;
   logic grant_dm;
   logic cnt_zero;
   logic if_kill;
   logic unused_addr_bits;

   // Fetches are held off while halted or being redirected
   assign if_elig = if_req_i & ~halt_i & ~if_flush_i;
   assign any_req = dm_req_i | if_elig;

`ifdef ARB_ROUND_ROBIN_EN
   assign grant_dm = dm_req_i & (~if_elig | (last_owner_q == OWNER_IF));
`else
   assign grant_dm = dm_req_i;
`endif

   // A fetch flushed at any point of its timeline must not deliver data
   assign if_kill = flush_q | if_flush_i;

   assign unused_addr_bits = ^{if_addr_i[31:MEM_ADDR_W+2], if_addr_i[1:0],
                               dm_addr_i[31:MEM_ADDR_W+2], dm_addr_i[1:0]};

   arb_wait_counter #(
      .MEM_LATENCY(MEM_LATENCY)
   ) u_wait_cnt (
      .clk   (clk),
      .rst   (rst),
      .load_i(state_q == ARB_ISSUE),
      .dec_i (state_q == ARB_WAIT),
      .zero_o(cnt_zero)
   );

   // Transaction FSM with registered memory strobes, acks and read data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         owner_q      <= OWNER_IF;
         store_q      <= 1'b0;
         flush_q      <= 1'b0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_be_q     <= 4'b0000;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         if_ack_q     <= 1'b0;
         dm_ack_q     <= 1'b0;
         if_rdata_q   <= '0;
         dm_rdata_q   <= '0;
         busy_q       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_owner_q <= OWNER_IF;
`endif
      end else begin
         if_ack_q <= 1'b0;
         dm_ack_q <= 1'b0;
         case (state_q)
            ARB_IDLE: begin
               flush_q <= 1'b0;
               if (any_req) begin
                  state_q  <= ARB_ISSUE;
                  busy_q   <= 1'b1;
                  mem_en_q <= 1'b1;
                  if (grant_dm) begin
                     owner_q     <= OWNER_DM;
                     store_q     <= dm_we_i;
                     mem_we_q    <= dm_we_i;
                     mem_be_q    <= dm_be_i;
                     mem_addr_q  <= dm_addr_i[MEM_ADDR_W+1:2];
                     mem_wdata_q <= dm_wdata_i;
                  end else begin
                     owner_q     <= OWNER_IF;
                     store_q     <= 1'b0;
                     mem_we_q    <= 1'b0;
                     mem_be_q    <= 4'b1111;
                     mem_addr_q  <= if_addr_i[MEM_ADDR_W+1:2];
                     mem_wdata_q <= '0;
                  end
               end
            end
            ARB_ISSUE: begin
               state_q  <= ARB_WAIT;
               mem_en_q <= 1'b0;
               mem_we_q <= 1'b0;
               if ((owner_q == OWNER_IF) && if_flush_i) begin
                  flush_q <= 1'b1;
               end
`ifdef ARB_ROUND_ROBIN_EN
               last_owner_q <= owner_q;
`endif
            end
            ARB_WAIT: begin
               if ((owner_q == OWNER_IF) && if_flush_i) begin
                  flush_q <= 1'b1;
               end
               if (cnt_zero) begin
                  state_q <= ARB_RESP;
                  if (owner_q == OWNER_DM) begin
                     dm_ack_q <= 1'b1;
                     if (!store_q) begin
                        dm_rdata_q <= mem_rdata_i;
                     end
                  end else if (!if_kill) begin
                     if_ack_q   <= 1'b1;
                     if_rdata_q <= mem_rdata_i;
                  end
               end
            end
            default: begin
               state_q <= ARB_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // A flush arriving in the response cycle still cancels the fetch ack
   assign if_ack_o    = if_ack_q & ~if_flush_i;
   assign dm_ack_o    = dm_ack_q;
   assign if_rdata_o  = if_rdata_q;
   assign dm_rdata_o  = dm_rdata_q;
   assign mem_en_o    = mem_en_q;
   assign mem_we_o    = mem_we_q;
   assign mem_be_o    = mem_be_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign busy_o      = busy_q;
   assign owner_o     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with MEM_LATENCY=2 and a memory
// model returning read data two cycles after mem_en.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_flush, halt;
   logic [31:0] if_addr;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        dm_req, dm_we;
   logic [3:0]  dm_be;
   logic [31:0] dm_addr, dm_wdata;
   logic        dm_ack;
   logic [31:0] dm_rdata;
   logic        mem_en, mem_we;
   logic [3:0]  mem_be;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy, owner;

   logic [31:0] mem [0:1023];
   logic [31:0] rd_p1;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   mem_port_arbiter #(.MEM_ADDR_W(10), .MEM_LATENCY(2)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush), .halt_i(halt),
      .if_ack_o(if_ack), .if_rdata_o(if_rdata),
      .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_be_i(dm_be), .dm_addr_i(dm_addr),
      .dm_wdata_i(dm_wdata), .dm_ack_o(dm_ack), .dm_rdata_o(dm_rdata),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
      .busy_o(busy), .owner_o(owner)
   );

   always #5 clk = ~clk;

   // Memory model: two-stage read pipe, byte-enabled write
   always @(posedge clk) begin
      rd_p1     <= mem[mem_addr];
      mem_rdata <= rd_p1;
      if (mem_en && mem_we) begin
         for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      if_req = 0; if_flush = 0; halt = 0; if_addr = 0;
      dm_req = 0; dm_we = 0; dm_be = 0; dm_addr = 0; dm_wdata = 0;
      repeat (3) tick();
      chk_cnt++;
      if ({if_ack, dm_ack, mem_en, mem_we, busy, owner, mem_be} !== 10'd0 ||
          if_rdata !== 32'd0 || dm_rdata !== 32'd0 || mem_addr !== 10'd0 || mem_wdata !== 32'd0)
         $display("FAIL reset_outputs: ctl=%b if_rdata=%h dm_rdata=%h addr=%h, required all zero",
                  {if_ack, dm_ack, mem_en, mem_we, busy, owner, mem_be}, if_rdata, dm_rdata, mem_addr);
      else pass_cnt++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_fetch();
      tick();
      if_req = 1; if_addr = 32'h10;
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (c == 1) begin
            chk_cnt++;
            if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'd4 || mem_be !== 4'b1111 || owner !== 1'b0)
               $display("FAIL fetch_issue: en=%b we=%b addr=%h be=%b owner=%b, required 1 0 004 1111 0",
                        mem_en, mem_we, mem_addr, mem_be, owner);
            else pass_cnt++;
         end
         chk_cnt++;
         if (if_ack !== (c == 4))
            $display("FAIL fetch_ack cyc%0d: got %b, required %b", c, if_ack, (c == 4));
         else pass_cnt++;
      end
      chk_cnt++;
      if (if_rdata !== 32'h00500093)
         $display("FAIL fetch_rdata: got %h, required 00500093", if_rdata);
      else pass_cnt++;
      if_req = 0;
   endtask

   task automatic test_contention();
      tick();
      if_req = 1; if_addr = 32'h10;
      dm_req = 1; dm_we = 0; dm_be = 4'b1111; dm_addr = 32'h100;
      for (int c = 1; c <= 9; c++) begin
         tick();
         chk_cnt++;
         if (mem_en !== (c == 1 || c == 6) || dm_ack !== (c == 4) || if_ack !== (c == 9))
            $display("FAIL contention cyc%0d: en=%b dm_ack=%b if_ack=%b, required %b %b %b",
                     c, mem_en, dm_ack, if_ack, (c == 1 || c == 6), (c == 4), (c == 9));
         else pass_cnt++;
         if (c == 1) begin
            chk_cnt++;
            if (mem_addr !== 10'h40 || owner !== 1'b1)
               $display("FAIL contention_dm_grant: addr=%h owner=%b, required 040 1", mem_addr, owner);
            else pass_cnt++;
         end
         if (c == 6) begin
            chk_cnt++;
            if (mem_addr !== 10'h4 || owner !== 1'b0)
               $display("FAIL contention_if_grant: addr=%h owner=%b, required 004 0", mem_addr, owner);
            else pass_cnt++;
         end
         if (c == 4) begin
            chk_cnt++;
            if (dm_rdata !== 32'h11223344)
               $display("FAIL contention_dm_rdata: got %h, required 11223344", dm_rdata);
            else pass_cnt++;
            dm_req = 0;
         end
      end
      if_req = 0;
   endtask

   task automatic test_store();
      tick();
      dm_req = 1; dm_we = 1; dm_be = 4'b0011; dm_addr = 32'h8; dm_wdata = 32'hDEADBEEF;
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (c == 1) begin
            chk_cnt++;
            if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'd2 || mem_be !== 4'b0011 || mem_wdata !== 32'hDEADBEEF)
               $display("FAIL store_issue: en=%b we=%b addr=%h be=%b wdata=%h, required 1 1 002 0011 deadbeef",
                        mem_en, mem_we, mem_addr, mem_be, mem_wdata);
            else pass_cnt++;
         end
         chk_cnt++;
         if (dm_ack !== (c == 4))
            $display("FAIL store_ack cyc%0d: got %b, required %b", c, dm_ack, (c == 4));
         else pass_cnt++;
      end
      chk_cnt++;
      if (dm_rdata !== 32'h11223344 || mem[2] !== 32'h0000BEEF)
         $display("FAIL store_result: dm_rdata=%h mem2=%h, required 11223344 0000beef", dm_rdata, mem[2]);
      else pass_cnt++;
      dm_req = 0; dm_we = 0;
   endtask

   task automatic test_flush();
      tick();
      if_req = 1; if_addr = 32'h14;
      for (int c = 1; c <= 5; c++) begin
         tick();
         if (c == 2) begin if_flush = 1; if_req = 0; end
         if (c == 3) if_flush = 0;
         chk_cnt++;
         if (if_ack !== 1'b0)
            $display("FAIL flush_no_ack cyc%0d: got %b, required 0", c, if_ack);
         else pass_cnt++;
      end
      chk_cnt++;
      if (busy !== 1'b0 || if_rdata !== 32'h00500093)
         $display("FAIL flush_end: busy=%b if_rdata=%h, required 0 00500093", busy, if_rdata);
      else pass_cnt++;
   endtask

   task automatic test_halt();
      tick();
      halt = 1; if_req = 1; if_addr = 32'h10;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == 3) begin dm_req = 1; dm_we = 0; dm_addr = 32'h100; end
         if (c == 7) dm_req = 0;
         chk_cnt++;
         if (mem_en !== (c == 4) || dm_ack !== (c == 7) || if_ack !== 1'b0)
            $display("FAIL halt cyc%0d: en=%b dm_ack=%b if_ack=%b, required %b %b 0",
                     c, mem_en, dm_ack, if_ack, (c == 4), (c == 7));
         else pass_cnt++;
      end
      if_req = 0; halt = 0;
   endtask

   task automatic test_reset_mid();
      logic [1:0] exp_own [4];
      int k;
      tick();
      if_req = 1; if_addr = 32'h10;
      tick();
      tick();
      rst = 1;
      #1;
      chk_cnt++;
      if ({if_ack, dm_ack, mem_en, mem_we, busy, owner} !== 6'd0 || if_rdata !== 32'd0 ||
          dm_rdata !== 32'd0 || mem_addr !== 10'd0 || mem_be !== 4'd0)
         $display("FAIL reset_mid: ctl=%b if_rdata=%h dm_rdata=%h addr=%h, required all zero",
                  {if_ack, dm_ack, mem_en, mem_we, busy, owner}, if_rdata, dm_rdata, mem_addr);
      else pass_cnt++;
      if_req = 0;
      #2 rst = 0;
      for (int c = 1; c <= 4; c++) begin
         tick();
         chk_cnt++;
         if (if_ack !== 1'b0 || mem_en !== 1'b0)
            $display("FAIL reset_no_ack cyc%0d: if_ack=%b en=%b, required 0 0", c, if_ack, mem_en);
         else pass_cnt++;
      end
      // Both requesters held high: grant order depends on arbitration mode
`ifdef ARB_ROUND_ROBIN_EN
      exp_own = '{2'd1, 2'd0, 2'd1, 2'd0};
`else
      exp_own = '{2'd1, 2'd1, 2'd1, 2'd1};
`endif
      k = 0;
      if_req = 1; if_addr = 32'h10;
      dm_req = 1; dm_we = 0; dm_addr = 32'h100;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (mem_en && k < 4) begin
            chk_cnt++;
            if ({1'b0, owner} !== exp_own[k])
               $display("FAIL grant_order %0d: owner=%b, required %0d", k, owner, exp_own[k]);
            else pass_cnt++;
            k++;
         end
      end
      chk_cnt++;
      if (k !== 4)
         $display("FAIL grant_count: got %0d grants, required 4", k);
      else pass_cnt++;
      if_req = 0; dm_req = 0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[4]    = 32'h00500093;
      mem[5]    = 32'hCAFEF00D;
      mem[10'h40] = 32'h11223344;
      test_reset();
      test_fetch();
      test_contention();
      test_store();
      test_flush();
      test_halt();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
